// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: reset PC, NOP encoding,
// FSM state encoding and the sequential-PC helper.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [31:0] NOP_INST     = 32'h00000000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_CANCEL = 2'd3
    } fetch_state_e;

    // Sequential fetch address; wraps modulo 2^32, alignment is checked elsewhere.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry {pc, inst} FIFO between fetch and decode, with push, pop, flush and
// an occupancy count. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic [31:0]                  push_pc,
    input  logic [31:0]                  push_inst,
    input  logic                         pop,
    input  logic                         flush,
    output logic [31:0]                  head_pc,
    output logic [31:0]                  head_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one i-mem request in flight,
// buffers returned instructions for decode and discards responses cancelled by a redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  req_pc, req_pc_next;

    logic          redir;
    logic [31:0]   target;
    logic          in_flight;
    logic          pop;
    logic          push;
    logic          space;
    logic [CW:0]   occ;
    logic [CW-1:0] buf_count;
    logic [31:0]   head_pc;
    logic [31:0]   head_inst;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    // An in-flight request reserves a queue slot so its response always has room.
    always_comb begin
        redir     = exc_valid | br_valid;
        target    = exc_valid ? exc_pc : br_target;
        in_flight = (state == S_WAIT) || (state == S_CANCEL);
        pop       = out_valid & out_ready;
        occ       = {1'b0, buf_count} + (CW+1)'(in_flight) - (CW+1)'(pop);
        space     = occ < (CW+1)'(DEPTH);
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        inst_req    = 1'b0;
        push        = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                if (redir) pc_next = target;
            end
            S_REQ: begin
                inst_req = space;
                if (inst_req && inst_addr_ok) begin
                    if (redir) begin
                        pc_next    = target;
                        state_next = S_CANCEL;
                    end else begin
                        req_pc_next = pc;
                        pc_next     = next_seq_pc(pc);
                        state_next  = S_WAIT;
                    end
                end else if (redir) begin
                    pc_next = target;
                end
            end
            S_WAIT: begin
                if (redir) pc_next = target;
                if (inst_data_ok) begin
                    push       = ~redir;
                    state_next = S_REQ;
                end else if (redir) begin
                    state_next = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (redir) pc_next = target;
                if (inst_data_ok) state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign inst_addr = pc;

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_pc   (req_pc),
        .push_inst (inst_rdata),
        .pop       (pop),
        .flush     (redir),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .count     (buf_count)
    );

    assign out_valid = (buf_count != '0);
    assign out_pc    = out_valid ? head_pc   : 32'h0;
    assign out_inst  = out_valid ? head_inst : NOP_INST;

    a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
        !(push && buf_count == CW'(DEPTH)));

    a_no_stray_data: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_data_ok && (state == S_IDLE || state == S_REQ)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a directed vector table, hand-written redirect,
// wrap and reset sequences, and a randomized run against a queue-based reference model.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    typedef struct {
        logic        rn, br, ex, aok, dok, rdy;
        logic [31:0] bt, ep, rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        resetn, br_valid, exc_valid, inst_addr_ok, inst_data_ok, out_ready;
    logic [31:0] br_target, exc_pc, inst_rdata;
    logic        inst_req, out_valid;
    logic [31:0] inst_addr, out_pc, out_inst;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: fetch progress as flags plus a plain queue of fetched entries.
    bit          m_started, m_out, m_stale;
    logic [31:0] m_pc, m_req_pc;
    ent_t        m_q[$];

    logic        obs_req, obs_ov;
    logic [31:0] obs_addr, obs_pc, obs_inst;

    vec_t tab[$];

    fetch_ctrl #(.RESET_PC(32'hbfc00000), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit rn, input bit br, input logic [31:0] bt,
                                input bit ex, input logic [31:0] ep, input bit aok,
                                input bit dok, input logic [31:0] rd, input bit rdy,
                                input bit er, input logic [31:0] ea, input bit eov,
                                input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.rn = rn; v.br = br; v.bt = bt; v.ex = ex; v.ep = ep; v.aok = aok;
        v.dok = dok; v.rdata = rd; v.rdy = rdy; v.e_req = er; v.e_addr = ea;
        v.e_ov = eov; v.e_pc = epc; v.e_inst = einst;
        return v;
    endfunction

    function automatic vec_t idleVec(input bit rdy);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, rdy, 0, 0, 0, 0, 0);
    endfunction

    task automatic modelReset();
        m_started = 0; m_out = 0; m_stale = 0;
        m_pc = 32'hbfc00000; m_req_pc = 32'hbfc00000;
        m_q.delete();
    endtask

    task automatic modelEdge(input vec_t v, input bit e_req);
        bit          redir, do_push, do_pop;
        logic [31:0] tgt;
        if (!v.rn) begin
            modelReset();
            return;
        end
        redir   = v.br | v.ex;
        tgt     = v.ex ? v.ep : v.bt;
        do_push = 0;
        do_pop  = (m_q.size() > 0) && v.rdy;
        if (!m_started) begin
            m_started = 1;
            if (redir) m_pc = tgt;
        end else if (!m_out) begin
            if (e_req && v.aok) begin
                m_out   = 1;
                m_stale = redir;
                if (redir) m_pc = tgt;
                else begin
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end else if (redir) m_pc = tgt;
        end else begin
            if (redir) m_pc = tgt;
            if (v.dok) begin
                m_out   = 0;
                do_push = !m_stale && !redir;
            end else if (redir) m_stale = 1;
        end
        if (redir) m_q.delete();
        else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back('{pc: m_req_pc, inst: v.rdata});
        end
    endtask

    // One clock: drive inputs, compare mid-cycle against the model (and table), advance.
    task automatic applyStimulus(input vec_t v, input bit use_tab, input string tag);
        bit          e_req, e_ov, mpop;
        logic [31:0] e_pc, e_inst;
        resetn = v.rn; br_valid = v.br; br_target = v.bt; exc_valid = v.ex; exc_pc = v.ep;
        inst_addr_ok = v.aok; inst_data_ok = v.dok; inst_rdata = v.rdata; out_ready = v.rdy;
        @(negedge clk);
        mpop   = (m_q.size() > 0) && v.rdy;
        e_req  = m_started && !m_out && ((m_q.size() - int'(mpop)) < DEPTH);
        e_ov   = m_q.size() > 0;
        e_pc   = e_ov ? m_q[0].pc : 32'h0;
        e_inst = e_ov ? m_q[0].inst : 32'h0;
        obs_req = inst_req; obs_addr = inst_addr; obs_ov = out_valid;
        obs_pc = out_pc; obs_inst = out_inst;
        checkOutput({tag, "_req"},  {31'b0, obs_req}, {31'b0, e_req});
        checkOutput({tag, "_addr"}, obs_addr, m_pc);
        checkOutput({tag, "_ov"},   {31'b0, obs_ov},  {31'b0, e_ov});
        checkOutput({tag, "_pc"},   obs_pc, e_pc);
        checkOutput({tag, "_inst"}, obs_inst, e_inst);
        if (use_tab) begin
            checkOutput({tag, "_tab_req"},  {31'b0, obs_req}, {31'b0, v.e_req});
            checkOutput({tag, "_tab_addr"}, obs_addr, v.e_addr);
            checkOutput({tag, "_tab_ov"},   {31'b0, obs_ov},  {31'b0, v.e_ov});
            checkOutput({tag, "_tab_pc"},   obs_pc, v.e_pc);
            checkOutput({tag, "_tab_inst"}, obs_inst, v.e_inst);
        end
        @(posedge clk);
        modelEdge(v, e_req);
        #1;
    endtask

    task automatic imemCycles(input int n, input bit rdy, input string tag);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = idleVec(rdy);
            v.aok = 1; v.dok = m_out; v.rdata = $urandom;
            applyStimulus(v, 0, tag);
        end
    endtask

    initial begin
        vec_t v;
        resetn = 0; br_valid = 0; exc_valid = 0; br_target = 0; exc_pc = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0; out_ready = 0;
        @(posedge clk);
        modelReset();
        #1;

        // Sequential fetch, then a branch in WAIT with the stale response 3 cycles later.
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            0,32'hbfc00000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            1,32'hbfc00000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 1,0,0,1,            1,32'hbfc00000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            0,32'hbfc00004,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,1,32'h11110001,1, 0,32'hbfc00004,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            1,32'hbfc00004,1,32'hbfc00000,32'h11110001));
        tab.push_back(mk(1,0,0,0,0, 1,0,0,1,            1,32'hbfc00004,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            0,32'hbfc00008,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,1,32'h22220002,1, 0,32'hbfc00008,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            1,32'hbfc00008,1,32'hbfc00004,32'h22220002));
        tab.push_back(mk(1,0,0,0,0, 1,0,0,1,            1,32'hbfc00008,0,0,0));
        tab.push_back(mk(1,1,32'h80001000,0,0, 0,0,0,1, 0,32'hbfc0000c,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            0,32'h80001000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            0,32'h80001000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,1,32'hdeadbeef,1, 0,32'h80001000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            1,32'h80001000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 1,0,0,1,            1,32'h80001000,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,1,32'h33330003,1, 0,32'h80001004,0,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,1,            1,32'h80001004,1,32'h80001000,32'h33330003));
        foreach (tab[i]) applyStimulus(tab[i], 1, $sformatf("tab%0d", i));

        // Backpressure: two entries queue up and requests stop until decode pops.
        imemCycles(10, 0, "bp");
        checkOutput("bp_req_stalled", {31'b0, obs_req}, 32'h0);
        checkOutput("bp_queue_full_valid", {31'b0, obs_ov}, 32'h1);
        v = idleVec(1);
        applyStimulus(v, 0, "bp_drain");
        checkOutput("bp_drain_valid", {31'b0, obs_ov}, 32'h1);
        applyStimulus(v, 0, "bp_drain");
        applyStimulus(v, 0, "bp_drain");

        // Simultaneous branch and exception while full: exception wins, queue flushed.
        imemCycles(8, 0, "full");
        checkOutput("full_valid", {31'b0, obs_ov}, 32'h1);
        v = idleVec(0);
        v.br = 1; v.bt = 32'h80002000; v.ex = 1; v.ep = 32'hbfc00380;
        applyStimulus(v, 0, "bx");
        applyStimulus(idleVec(0), 0, "bx_after");
        checkOutput("bx_flushed", {31'b0, obs_ov}, 32'h0);
        checkOutput("bx_addr", obs_addr, 32'hbfc00380);
        checkOutput("bx_req", {31'b0, obs_req}, 32'h1);

        // Redirect in the addr_ok cycle: response dropped, target fetched next.
        v = idleVec(1); v.aok = 1; v.br = 1; v.bt = 32'h80003000;
        applyStimulus(v, 0, "rc");
        v = idleVec(1); v.dok = 1; v.rdata = 32'hbad0bad0;
        applyStimulus(v, 0, "rc_drop");
        applyStimulus(idleVec(1), 0, "rc_after");
        checkOutput("rc_dropped", {31'b0, obs_ov}, 32'h0);
        checkOutput("rc_addr", obs_addr, 32'h80003000);
        checkOutput("rc_req", {31'b0, obs_req}, 32'h1);
        imemCycles(6, 1, "rc_run");

        // PC wrap from 0xfffffffc, then reset while a fetch is outstanding.
        for (int i = 0; i < 8 && !(m_started && !m_out); i++) begin
            v = idleVec(1); v.dok = m_out;
            applyStimulus(v, 0, "wr_sync");
        end
        v = idleVec(1); v.br = 1; v.bt = 32'hfffffffc;
        applyStimulus(v, 0, "wr_br");
        v = idleVec(1); v.aok = 1;
        applyStimulus(v, 0, "wr_issue");
        checkOutput("wr_issue_addr", obs_addr, 32'hfffffffc);
        applyStimulus(idleVec(1), 0, "wr_wait");
        checkOutput("wr_wrapped_addr", obs_addr, 32'h00000000);
        v = idleVec(1); v.rn = 0;
        applyStimulus(v, 0, "rst_mid");
        applyStimulus(idleVec(1), 0, "rst_idle");
        checkOutput("rst_req", {31'b0, obs_req}, 32'h0);
        checkOutput("rst_addr", obs_addr, 32'hbfc00000);
        checkOutput("rst_valid", {31'b0, obs_ov}, 32'h0);
        applyStimulus(idleVec(1), 0, "rst_req1");
        checkOutput("rst_first_req", {31'b0, obs_req}, 32'h1);
        checkOutput("rst_first_addr", obs_addr, 32'hbfc00000);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            v = idleVec($urandom_range(0, 9) < 6);
            v.rn    = ($urandom_range(0, 99) != 0);
            v.aok   = $urandom_range(0, 1);
            v.dok   = m_out && ($urandom_range(0, 1) == 1);
            v.rdata = $urandom;
            v.br    = ($urandom_range(0, 19) == 0);
            v.ex    = ($urandom_range(0, 29) == 0);
            v.bt    = ($urandom_range(0, 3) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
            v.ep    = $urandom & 32'hfffffffc;
            applyStimulus(v, 0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
